// File: rtl/result_packer.sv
// result_packer: packs 40-bit CNN results into 256-bit host DMA words.
// Each word carries up to six results, a filled-slot count and the packet
// sequence number. The last word of each packet is flagged with tlast.
module result_packer #(
    parameter int RESULTS_PER_PACKET = 60,
    parameter int SLOTS              = 6
) (
    input  logic         clk,
    input  logic         ap_rst_n,
    input  logic         clear,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic [39:0]  s_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [255:0] m_axis_tdata,
    output logic         m_axis_tlast,
    output logic [15:0]  packets_done
);

    localparam int              CW        = $clog2(RESULTS_PER_PACKET + 1);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(RESULTS_PER_PACKET - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [2:0]      LAST_SLOT = 3'(SLOTS - 1);

    // Accumulator: slot k lives at bits [40k+39:40k], slot 0 is the earliest.
    logic [SLOTS-1:0][39:0] acc_q, acc_d, word_slots;
    logic [2:0]             slot_idx_q, slot_idx_d;
    logic [CW-1:0]          res_cnt_q, res_cnt_d;
    logic [255:0]           out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [7:0]             pkt_seq_q, pkt_seq_d;
    logic [15:0]            pkts_done_q, pkts_done_d;

    logic completing;
    logic last_beat;
    logic accept;
    logic drain;

    // Completion depends only on internal counters, never on the input handshake.
    always_comb begin
        last_beat  = (res_cnt_q == LAST_CNT);
        completing = (slot_idx_q == LAST_SLOT) || last_beat;
    end

    // Ready is low during reset and clear, and stalls only a completing beat
    // that would overwrite a word the consumer has not yet taken.
    always_comb begin
        s_axis_tready = ap_rst_n && !clear &&
                        (!completing || !out_valid_q || m_axis_tready);
        accept        = s_axis_tvalid && s_axis_tready;
        drain         = out_valid_q && m_axis_tready;
    end

    // Next-state logic for the accumulator, counters and the output register.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        acc_d       = acc_q;
        slot_idx_d  = slot_idx_q;
        res_cnt_d   = res_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pkt_seq_d   = pkt_seq_q;
        pkts_done_d = pkts_done_q;
        word_slots  = acc_q;

        if (drain) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                pkt_seq_d   = pkt_seq_q + 8'd1;
                pkts_done_d = pkts_done_q + 16'd1;
            end
        end

        if (accept) begin
            if (completing) begin
                // The sequence field uses the post-drain value so a word that
                // starts a new packet in the same cycle the previous tlast word
                // leaves already carries the new number.
                word_slots[slot_idx_q] = s_axis_tdata;
                out_data_d  = {pkt_seq_d, ({5'd0, slot_idx_q} + 8'd1), word_slots};
                out_valid_d = 1'b1;
                out_last_d  = last_beat;
                acc_d       = '0;
                slot_idx_d  = 3'd0;
                res_cnt_d   = last_beat ? '0 : res_cnt_q + CNT_ONE;
            end else begin
                acc_d[slot_idx_q] = s_axis_tdata;
                slot_idx_d        = slot_idx_q + 3'd1;
                res_cnt_d         = res_cnt_q + CNT_ONE;
            end
        end

        // Clear overrides everything, including a word still being held.
        if (clear) begin
            acc_d       = '0;
            slot_idx_d  = 3'd0;
            res_cnt_d   = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            pkt_seq_d   = 8'd0;
            pkts_done_d = 16'd0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            // NOTE: the accumulator is reset along with the control state because
            // unfilled slots must read zero and reset has to discard partial data.
            acc_q       <= '0;
            slot_idx_q  <= 3'd0;
            res_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pkt_seq_q   <= 8'd0;
            pkts_done_q <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            acc_q       <= acc_d;
            slot_idx_q  <= slot_idx_d;
            res_cnt_q   <= res_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            pkt_seq_q   <= pkt_seq_d;
            pkts_done_q <= pkts_done_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign packets_done  = pkts_done_q;

endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: directed test of result_packer at 60, 8 and 1 results
// per packet. Transferred words are captured per instance and compared with
// hand-built expected words.
module tb_result_packer;

    logic         clk = 1'b0;
    logic         ap_rst_n;
    logic         clear   [3];
    logic         s_valid [3];
    logic         s_ready [3];
    logic [39:0]  s_data  [3];
    logic         m_valid [3];
    logic         m_ready [3];
    logic [255:0] m_data  [3];
    logic         m_last  [3];
    logic [15:0]  pkts    [3];

    logic [256:0] wq0[$];
    logic [256:0] wq1[$];
    logic [256:0] wq2[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    result_packer #(.RESULTS_PER_PACKET(60)) u_p60 (
        .clk(clk), .ap_rst_n(ap_rst_n), .clear(clear[0]),
        .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]), .s_axis_tdata(s_data[0]),
        .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]), .m_axis_tdata(m_data[0]),
        .m_axis_tlast(m_last[0]), .packets_done(pkts[0]));

    result_packer #(.RESULTS_PER_PACKET(8)) u_p8 (
        .clk(clk), .ap_rst_n(ap_rst_n), .clear(clear[1]),
        .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]), .s_axis_tdata(s_data[1]),
        .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]), .m_axis_tdata(m_data[1]),
        .m_axis_tlast(m_last[1]), .packets_done(pkts[1]));

    result_packer #(.RESULTS_PER_PACKET(1)) u_p1 (
        .clk(clk), .ap_rst_n(ap_rst_n), .clear(clear[2]),
        .s_axis_tvalid(s_valid[2]), .s_axis_tready(s_ready[2]), .s_axis_tdata(s_data[2]),
        .m_axis_tvalid(m_valid[2]), .m_axis_tready(m_ready[2]), .m_axis_tdata(m_data[2]),
        .m_axis_tlast(m_last[2]), .packets_done(pkts[2]));

    // Capture transferred words {tlast, tdata}; inputs only change on negedge.
    always @(negedge clk) begin
        #2;
        if (m_valid[0] && m_ready[0]) wq0.push_back({m_last[0], m_data[0]});
        if (m_valid[1] && m_ready[1]) wq1.push_back({m_last[1], m_data[1]});
        if (m_valid[2] && m_ready[2]) wq2.push_back({m_last[2], m_data[2]});
    end

    task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected word: cnt slots holding base, base+1, ..., rest zero.
    function automatic logic [256:0] mk(input logic last, input int seq, input int cnt, input int base);
        logic [256:0] w;
        w = '0;
        for (int k = 0; k < cnt; k++) w[40*k +: 40] = 40'(base + k);
        w[247:240] = 8'(cnt);
        w[255:248] = 8'(seq);
        w[256]     = last;
        return w;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Present one beat on instance u and hold it until accepted (bounded).
    task automatic send(input int u, input int d);
        int n;
        n = 0;
        s_valid[u] = 1'b1;
        s_data[u]  = 40'(d);
        #1;
        while (!s_ready[u] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_ready[u]) check("send_ready_timeout", 257'(s_ready[u]), 257'd1);
        @(negedge clk);
        s_valid[u] = 1'b0;
    endtask

    task automatic pop(input string tag, input int u, input logic [256:0] exp);
        logic [256:0] got;
        got = '1;
        case (u)
            0: if (wq0.size() > 0) got = wq0.pop_front();
            1: if (wq1.size() > 0) got = wq1.pop_front();
            default: if (wq2.size() > 0) got = wq2.pop_front();
        endcase
        check(tag, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            clear[u]   = 1'b0;
            s_valid[u] = 1'b1;
            s_data[u]  = 40'h55;
            m_ready[u] = 1'b1;
        end
        ap_rst_n = 1'b0;

        // Reset with tvalid held high.
        tick(3);
        #1;
        check("rst_s_ready",  257'(s_ready[0]), 257'd0);
        check("rst_m_valid",  257'(m_valid[0]), 257'd0);
        check("rst_pkts",     257'(pkts[0]),    257'd0);
        check("rst_m_data",   257'(m_data[0]),  257'd0);
        check("rst_s_ready1", 257'(s_ready[2]), 257'd0);
        for (int u = 0; u < 3; u++) s_valid[u] = 1'b0;
        @(negedge clk);
        ap_rst_n = 1'b1;
        #1;
        check("rel_s_ready", 257'(s_ready[0]), 257'd1);
        tick(1);

        // 60 results per packet, 0..59 back to back.
        for (int i = 0; i < 60; i++) send(0, i);
        tick(3);
        check("p60_nwords", 257'(wq0.size()), 257'd10);
        for (int i = 0; i < 10; i++) pop($sformatf("p60_w%0d", i), 0, mk(i == 9, 0, 6, 6 * i));
        check("p60_pkts", 257'(pkts[0]), 257'd1);

        // 8 results per packet, two packets.
        for (int i = 0; i < 16; i++) send(1, 100 + i);
        tick(3);
        check("p8_nwords", 257'(wq1.size()), 257'd4);
        pop("p8_w0", 1, mk(1'b0, 0, 6, 100));
        pop("p8_w1", 1, mk(1'b1, 0, 2, 106));
        pop("p8_w2", 1, mk(1'b0, 1, 6, 108));
        pop("p8_w3", 1, mk(1'b1, 1, 2, 114));
        check("p8_pkts", 257'(pkts[1]), 257'd2);

        // Backpressure on the 60-result instance (packet 1, seq 1).
        m_ready[0] = 1'b0;
        for (int i = 0; i < 6; i++) send(0, 60 + i);
        for (int j = 0; j < 5; j++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = 40'(66 + j);
            #1;
            check($sformatf("bp_acc%0d", j), 257'(s_ready[0]), 257'd1);
            @(negedge clk);
        end
        s_data[0] = 40'd71;
        #1;
        check("bp_stall",  257'(s_ready[0]), 257'd0);
        @(negedge clk);
        #1;
        check("bp_stall2", 257'(s_ready[0]), 257'd0);
        check("bp_held",   {m_last[0], m_data[0]}, mk(1'b0, 1, 6, 60));
        m_ready[0] = 1'b1;
        #1;
        check("bp_release", 257'(s_ready[0]), 257'd1);
        @(negedge clk);
        s_valid[0] = 1'b0;
        check("bp_nobubble_v", 257'(m_valid[0]), 257'd1);
        check("bp_nobubble_d", {m_last[0], m_data[0]}, mk(1'b0, 1, 6, 66));
        tick(2);
        pop("bp_wA", 0, mk(1'b0, 1, 6, 60));
        pop("bp_wB", 0, mk(1'b0, 1, 6, 66));

        // Clear with a held word and 3 accepted beats in the accumulator.
        m_ready[0] = 1'b0;
        for (int i = 0; i < 9; i++) send(0, 300 + i);
        clear[0]   = 1'b1;
        s_valid[0] = 1'b1;
        s_data[0]  = 40'd999;
        #1;
        check("clr_s_ready", 257'(s_ready[0]), 257'd0);
        @(negedge clk);
        clear[0]   = 1'b0;
        s_valid[0] = 1'b0;
        check("clr_m_valid", 257'(m_valid[0]), 257'd0);
        check("clr_pkts",    257'(pkts[0]),    257'd0);
        m_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) send(0, 200 + i);
        tick(3);
        check("clr_nwords", 257'(wq0.size()), 257'd1);
        pop("clr_w", 0, mk(1'b0, 0, 6, 200));

        // One result per packet: sequence and packet counter wrap.
        for (int i = 0; i < 256; i++) send(2, i);
        tick(3);
        check("wrap_pkts256", 257'(pkts[2]), 257'd256);
        send(2, 256);
        tick(3);
        check("wrap_nwords", 257'(wq2.size()), 257'd257);
        for (int i = 0; i < 257; i++) pop($sformatf("wrap_w%0d", i), 2, mk(1'b1, i % 256, 1, i));
        check("wrap_pkts257", 257'(pkts[2]), 257'd257);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Packs the 40-bit CNN results from the inference pipeline into 256-bit words for the host DMA path. Each word carries a slot count and a packet sequence number. A packet ends with tlast after a parameterised number of results.

Interface
REQ-001 Parameter RESULTS_PER_PACKET, default 60: number of 40-bit results per packet; legal range 1..65535.
REQ-002 Parameter SLOTS, fixed 6: number of result slots per output word.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 ap_rst_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous clear; discards any partial packet and resets all counters.
REQ-006 s_axis_tvalid  input  1  a result is present on s_axis_tdata.
REQ-007 s_axis_tready  output  1  the block accepts a result this cycle.
REQ-008 s_axis_tdata  input  40  one CNN result, treated as opaque.
REQ-009 m_axis_tvalid  output  1  a packed word is present on the output.
REQ-010 m_axis_tready  input  1  the downstream stage accepts the word.
REQ-011 m_axis_tdata  output  256  packed word; layout per REQ-016.
REQ-012 m_axis_tlast  output  1  last word of a packet.
REQ-013 packets_done  output  16  count of packets fully transferred, wrapping.

Function
REQ-014 An input beat is accepted when s_axis_tvalid and s_axis_tready are both 1.
- The result is written to slot slot_idx of the accumulator.
- slot_idx and res_cnt then advance.
REQ-015 A "completing" beat is one accepted with slot_idx == 5 or res_cnt == RESULTS_PER_PACKET-1.
- On a completing beat, the accumulator plus that beat is committed to the output register.
- m_axis_tvalid = 1 on the next cycle, i.e. one cycle of latency.
- slot_idx returns to 0 and the accumulator is zeroed.
REQ-016 Output word layout:
- [40k+39:40k] = slot k, for k = 0..5; slot 0 holds the earliest result.
- [247:240] = number of filled slots, 1..6.
- [255:248] = pkt_seq.
- Unfilled slots read 0.
REQ-017 m_axis_tlast = 1 only on the word committed by the beat with res_cnt == RESULTS_PER_PACKET-1.
- That beat also resets res_cnt to 0.
REQ-018 pkt_seq (8 bits) and packets_done (16 bits) increment when a tlast word is transferred (m_axis_tvalid and m_axis_tready both 1).
- Both wrap modulo 2^8 and 2^16 respectively.
REQ-019 s_axis_tready = !clear AND (not completing OR !m_axis_tvalid OR m_axis_tready).
- "Completing" here is evaluated from internal counters only.
- s_axis_tready has no dependency on s_axis_tvalid.
REQ-020 Simultaneous drain and commit: a held word transferring in the same cycle as a completing beat is accepted gives a new word on the next cycle with m_axis_tvalid still 1, with no bubble.
REQ-021 While m_axis_tvalid = 1 and m_axis_tready = 0:
- m_axis_tdata and m_axis_tlast hold stable.
- Non-completing beats continue to be accepted into the accumulator.
REQ-022 clear has priority over every other event.
- Next cycle: accumulator, slot_idx, res_cnt, pkt_seq and packets_done are all 0, and m_axis_tvalid = 0.
- Any held output word is dropped.
- An input beat presented during clear is not accepted, because s_axis_tready = 0.
REQ-023 RESULTS_PER_PACKET < 6 or not a multiple of 6: the final word of each packet is partial and carries the true slot count.
- RESULTS_PER_PACKET = 1: every word carries count 1 and tlast = 1.
REQ-024 Counter widths: res_cnt is $clog2(RESULTS_PER_PACKET+1) bits; slot_idx is 3 bits. No arithmetic overflows inside the legal parameter range.

Reset
REQ-025 While ap_rst_n = 0, asynchronously:
- m_axis_tvalid, m_axis_tlast = 0; m_axis_tdata = 0; packets_done = 0.
- Internal counters and the accumulator are 0.
- s_axis_tready = 0.
REQ-026 On the first cycle after ap_rst_n deasserts, s_axis_tready = 1.
REQ-027 Reset asserted mid-packet discards all partial and held data. No word is emitted for it after release.

Verification
REQ-028 Reset: hold ap_rst_n = 0 with tvalid = 1 -> s_axis_tready = 0, m_axis_tvalid = 0, packets_done = 0; release -> s_axis_tready = 1 next cycle.
REQ-029 RESULTS_PER_PACKET = 60, results 0..59 back-to-back, m_axis_tready = 1 ->
- 10 words; each count = 6, seq = 0.
- Word 0 slot 0 = 0, word 9 slot 5 = 59.
- tlast only on word 9; packets_done = 1.
REQ-030 RESULTS_PER_PACKET = 8, two packets ->
- Words in order: count 6 / tlast 0, then count 2 / tlast 1 with [239:80] = 0.
- Second packet's words carry seq = 1; packets_done = 2.
REQ-031 Backpressure: m_axis_tready = 0 after the first word ->
- 5 further beats accepted; the 6th sees s_axis_tready = 0.
- Raise m_axis_tready -> the 6th beat is accepted that cycle and the second word appears the next cycle, no bubble.
REQ-032 clear after 3 accepted beats, with a word held ->
- Next cycle m_axis_tvalid = 0 and packets_done = 0.
- The next 6 results produce a word with seq = 0 containing only the new data.
REQ-033 Wrap: 256 packets at RESULTS_PER_PACKET = 1 -> pkt_seq 255 -> 0 on packet 257; packets_done = 256 after packet 256.
